// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV load/store funct3
// encodings, FSM state type and access-size helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Access width in bytes; 0 marks the illegal encoding.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 4'd1;
      F3_H, F3_HU: return 4'd2;
      F3_W, F3_WU: return 4'd4;
      F3_D:        return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Selects the addressed bytes of a 64-bit word, right-aligns them and
// sign- or zero-extends according to the load funct3.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  byte_lane,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  logic [63:0] shifted;

  always_comb begin
    shifted = word >> {byte_lane, 3'b000};
    case (funct3)
      F3_B:    ext = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    ext = shifted;
      F3_BU:   ext = {56'd0, shifted[7:0]};
      F3_HU:   ext = {48'd0, shifted[15:0]};
      F3_WU:   ext = {32'd0, shifted[31:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for CPU data-memory loads/stores: one outstanding request,
// fixed programmable latency, byte-lane stores and extended load data.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [2:0]  cap_funct3;

  logic [63:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        go_resp;
  logic        cur_we;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic [AW-1:0] word_idx;
  logic        cur_err;
  logic        misaligned;
  logic [7:0]  size_mask;
  logic [7:0]  byte_en;
  logic [63:0] wdata_sh;
  logic [63:0] load_ext;
  logic [63:0] rdata_next;

  assign accept  = (state == IDLE) && req_valid_i && req_ready_o;
  assign go_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));

  // With zero latency the commit happens on the acceptance edge, so the
  // live request fields stand in for the not-yet-captured ones.
  always_comb begin
    cur_we     = cap_we;
    cur_addr   = cap_addr;
    cur_wdata  = cap_wdata;
    cur_funct3 = cap_funct3;
    if (state == IDLE) begin
      cur_we     = req_we_i;
      cur_addr   = req_addr_i;
      cur_wdata  = req_wdata_i;
      cur_funct3 = req_funct3_i;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (cur_funct3)
      F3_H, F3_HU: misaligned = cur_addr[0];
      F3_W, F3_WU: misaligned = |cur_addr[1:0];
      F3_D:        misaligned = |cur_addr[2:0];
      default:     misaligned = 1'b0;
    endcase
    cur_err = ((cur_addr >> (AW + 3)) != '0) || misaligned ||
              (cur_funct3 == 3'b111) || (cur_we && cur_funct3[2]);

    case (size_bytes(cur_funct3))
      4'd1:    size_mask = 8'h01;
      4'd2:    size_mask = 8'h03;
      4'd4:    size_mask = 8'h0F;
      4'd8:    size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    byte_en  = size_mask << cur_addr[2:0];
    wdata_sh = cur_wdata << {cur_addr[2:0], 3'b000};
    word_idx = cur_addr[3 +: AW];
  end

  dmem_load_extend u_load_extend (
    .word      (mem[word_idx]),
    .byte_lane (cur_addr[2:0]),
    .funct3    (cur_funct3),
    .ext       (load_ext)
  );

  assign rdata_next = (cur_we || cur_err) ? '0 : load_ext;

  always_ff @(posedge clk_i) begin
    if (!reset_i && go_resp && cur_we && !cur_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_funct3  <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            cap_we      <= req_we_i;
            cap_addr    <= req_addr_i;
            cap_wdata   <= req_wdata_i;
            cap_funct3  <= req_funct3_i;
            req_ready_o <= 1'b0;
            if (LATENCY == 0) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rdata_next;
              rsp_err_o   <= cur_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rdata_next;
            rsp_err_o   <= cur_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against a byte-array
// reference model of RV64 load/store semantics.
module tb_data_mem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_funct3_i (req_funct3_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit hold = 1'b0;
  always @(posedge clk) begin
    #1 rsp_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mm [DEPTH*8];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected normal progress (cycle %0d)", name, cyc);
  endtask

  // Reference: byte-addressed little-endian memory with RV64 sizing rules.
  function automatic void model(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [2:0] f3, output logic [63:0] rd, output logic err);
    int size = 1 << f3[1:0];
    err = (f3 == 3'b111) || (we && f3[2]) || (addr >= 64'(DEPTH * 8)) ||
          ((addr % 64'(size)) != 0);
    rd = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mm[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd |= 64'(mm[int'(addr) + i]) << (8 * i);
      if (!f3[2] && size < 8 && rd[8*size-1]) rd |= ~64'd0 << (8 * size);
    end
  endfunction

  task automatic issue(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] f3, input bit track);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      fail_now("req_ready_timeout");
      return;
    end
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_funct3_i = f3;
    if (track) begin
      model(we, addr, wdata, f3, e.rdata, e.err);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i  = 1'b0;
    req_we_i     = $urandom_range(0, 1);
    req_addr_i   = {$urandom, $urandom};
    req_wdata_i  = {$urandom, $urandom};
    req_funct3_i = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  // Monitor: latency, stability under backpressure, handshake payload.
  bit prev_valid = 1'b0;
  bit chk_ready_next = 1'b0;
  logic [63:0] last_rdata;
  logic        last_err;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        prev_valid = 1'b0;
        chk_ready_next = 1'b0;
      end else begin
        if (chk_ready_next) begin
          check("ready_after_rsp", 64'(req_ready_o), 64'd1);
          chk_ready_next = 1'b0;
        end
        if (rsp_valid_o) begin
          check("ready_low_in_resp", 64'(req_ready_o), 64'd0);
          if (!prev_valid) begin
            if (sb.size() == 0) fail_now("unexpected_rsp");
            else check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
          end else begin
            check("stable_rdata", rsp_rdata_o, last_rdata);
            check("stable_err", 64'(rsp_err_o), 64'(last_err));
          end
          last_rdata = rsp_rdata_o;
          last_err   = rsp_err_o;
          if (rsp_ready_i && sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata_o, e.rdata);
            check("rsp_err", 64'(rsp_err_o), 64'(e.err));
            chk_ready_next = 1'b1;
            prev_valid = 1'b0;
          end else begin
            prev_valid = 1'b1;
          end
        end else begin
          prev_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [2:0]  f;
    int r;
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 64'(req_ready_o), 64'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready_o), 64'd1);
    check("valid_after_reset", 64'(rsp_valid_o), 64'd0);
    check("rdata_after_reset", rsp_rdata_o, 64'd0);
    check("err_after_reset", 64'(rsp_err_o), 64'd0);

    for (int w = 0; w < 32; w++) issue(1'b1, 64'(w * 8), {$urandom, $urandom}, 3'b011, 1'b1);

    issue(1'b1, 64'h40, 64'h1122334455667788, 3'b011, 1'b1);
    issue(1'b0, 64'h40, '0, 3'b011, 1'b1);
    issue(1'b1, 64'h43, 64'h80, 3'b000, 1'b1);
    issue(1'b0, 64'h43, '0, 3'b000, 1'b1);
    issue(1'b0, 64'h43, '0, 3'b100, 1'b1);
    issue(1'b0, 64'h40, '0, 3'b010, 1'b1);
    issue(1'b0, 64'h41, '0, 3'b001, 1'b1);
    issue(1'b1, 64'h1002, 64'hDEADBEEF, 3'b010, 1'b1);
    issue(1'b1, 64'h42, 64'hCAFEF00D, 3'b010, 1'b1);
    issue(1'b0, 64'h40, '0, 3'b011, 1'b1);
    issue(1'b0, 64'(DEPTH * 8), '0, 3'b011, 1'b1);
    issue(1'b0, 64'h48, '0, 3'b111, 1'b1);
    issue(1'b1, 64'h48, 64'h55, 3'b100, 1'b1);
    drain();

    // Backpressure: response held for several cycles.
    hold = 1'b1;
    issue(1'b0, 64'h40, '0, 3'b011, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_o) fail_now("bp_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 64'(rsp_valid_o), 64'd1);
    end
    hold = 1'b0;
    drain();

    // Reset while the store sits in WAIT: it must be dropped entirely.
    issue(1'b1, 64'h80, 64'hA5A5A5A5A5A5A5A5, 3'b011, 1'b0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("ready_in_midreset", 64'(req_ready_o), 64'd0);
    check("valid_in_midreset", 64'(rsp_valid_o), 64'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o) n++;
    end
    check("no_rsp_after_abort", 64'(n), 64'd0);
    issue(1'b0, 64'h80, '0, 3'b011, 1'b1);
    drain();

    for (int k = 0; k < 250; k++) begin
      f = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r == 0) a = 64'(4096 + $urandom_range(0, 255));
      else a = 64'($urandom_range(0, 255));
      if (r >= 5) a = a & ~(64'((1 << f[1:0]) - 1));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, f, 1'b1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
